teller_dispatch: RTL and testbench
==================================

// Module: teller_dispatch
// PURPOSE
//  Sequences the bank queue between customers and tellers. Counts customer arrivals
//  into a bounded queue and issues ticket numbers. Latches "call next" requests from
//  open tellers and grants the head-of-queue customer to one teller per cycle,
//  round-robin. Drives the queue status and ticket/teller values to the display and ROM paths.
// PARAMETERS
//  NT          4   number of tellers (1..4)
//  QDEPTH      7   queue capacity in persons
//  TW          8   ticket counter width
//  MAX_TICKET  99  last ticket value before wrap to 0 (two BCD digits downstream)
// PORTS
//  clk           in   1       system clock
//  RST           in   1       asynchronous reset, active-low
//  arrive_pb     in   1       customer arrival push button (raw, asynchronous)
//  teller_pb     in   NT      per-teller "call next" push buttons (raw, asynchronous)
//  teller_en     in   NT      teller open switches (level, quasi-static)
//  q_count       out  3       persons waiting, 0..QDEPTH
//  EF            out  1       queue empty (q_count==0)
//  FF            out  1       queue full (q_count==QDEPTH)
//  arrive_rej    out  1       1-cycle pulse: arrival dropped because the queue is full
//  serve_valid   out  1       1-cycle pulse: customer granted to a teller
//  serve_teller  out  2       index of the granted teller (valid with serve_valid, held after)
//  serve_ticket  out  TW      ticket of the last served customer
//  next_ticket   out  TW      ticket the next arrival receives
//  open_tellers  out  2       number of enabled tellers minus 1 (0 when none; ROM address field)
//  teller_busy   out  NT      per-teller pending request not yet granted
// BEHAVIOUR
//  Reset (RST=0, async): every register and output = 0, except EF=1. Sync chains cleared.
//  Inputs: each push button passes 2-FF sync + rising-edge detect = 1-cycle pulse.
//   The pulse is high in the 3rd cycle after the first sampling edge. A held button gives one pulse.
//  Arrival pulse:
//   q_count<QDEPTH -> q_count+1, next_ticket+1 (MAX_TICKET wraps to 0).
//   Otherwise -> arrive_rej pulse; count and ticket unchanged.
//  Teller pulse: sets pend[i] only if teller_en[i]=1. pend[i] is cleared when teller_en[i]=0.
//   A pulse while pend[i]=1 is ignored (no queueing of repeats).
//  Arbiter: each cycle with q_count>0 and any pend set, grant exactly one teller.
//   Search order is rr_ptr+1, +2, ... wrapping mod NT.
//   On grant: serve_valid=1 next cycle, serve_teller=i, pend[i] cleared, rr_ptr=i,
//   q_count-1, serve_ticket=ticket issued to that customer (serve_ticket+1 with wrap).
//   The first grant after reset serves ticket 1; next_ticket starts at 1 after the first arrival.
//  Latency: teller button edge -> serve_valid high 4 clk edges later when the queue is non-empty.
//  Simultaneous arrival + grant, same cycle:
//   q_count>0 -> both take effect, q_count unchanged (FF stays set when full).
//   q_count==0 -> arrival only; grant on the following cycle.
//  Empty queue: pend stays set (teller_busy=1) until a customer arrives.
//  Invariant checked by bench: q_count == (next_ticket - serve_ticket) mod (MAX_TICKET+1).
//  EF/FF registered from the next q_count value, so they update in the same cycle as q_count.
//   q_count never exceeds QDEPTH; any illegal value forces q_count=0, EF=1.
//  teller_en all 0: no grants; customers accumulate up to QDEPTH.
// STRUCTURE
//  Shared package bank_pkg holds: QDEPTH, MAX_TICKET, TW, NT constants; the teller-index width;
//   function wrap_inc(ticket) used by the ticket counters.
//  Sub-module pb_sync_edge (clk, RST, pb_in -> pulse_out): 2-FF sync + edge detect,
//   instantiated 1+NT times. Arbiter and counters stay inline.
// TESTING
//  1 reset mid-operation: q_count=5, pend=4'b0011, RST low -> all outputs 0, EF=1, next pulse ignored until RST high.
//  2 fill: 8 arrival presses, no tellers -> q_count 1..7, FF=1 after 7th, 8th gives arrive_rej, next_ticket=7.
//  3 round-robin: q_count=4, teller_pb=4'b1111 same cycle -> grants on consecutive cycles to teller 0,1,2,3, serve_ticket 1..4, EF=1.
//  4 empty wait: queue empty, teller 2 presses -> teller_busy[2]=1; arrival -> serve_valid 1 cycle after count hits 1, serve_teller=2.
//  5 simultaneous: q_count=7, arrival and grant same cycle -> q_count stays 7, FF=1, arrive_rej=0, next_ticket+1, serve_ticket+1.
//  6 wrap/disable: next_ticket=99 then arrival -> 0; teller_en[1] low while pend[1]=1 -> pend cleared, no grant to teller 1.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared constants and helpers for the bank queue dispatcher.
// Ticket numbers run 0..MAX_TICKET and wrap.
package bank_pkg;

  localparam int NT         = 4;
  localparam int QDEPTH     = 7;
  localparam int TW         = 8;
  localparam int MAX_TICKET = 99;
  localparam int QW         = 3;
  localparam int TIW        = 2;

  function automatic logic [TW-1:0] wrap_inc(
    input logic [TW-1:0] t
  );
    if (t == TW'(MAX_TICKET))
      return '0;
    return t + 1'b1;
  endfunction

endpackage

// File: rtl/teller_dispatch_if.sv
// Bundle between the front panel / display side and the dispatcher.
// master drives buttons and switches, slave drives status.
interface teller_dispatch_if;
  import bank_pkg::*;

  logic           arrive_pb;
  logic [NT-1:0]  teller_pb;
  logic [NT-1:0]  teller_en;
  logic [QW-1:0]  q_count;
  logic           EF;
  logic           FF;
  logic           arrive_rej;
  logic           serve_valid;
  logic [TIW-1:0] serve_teller;
  logic [TW-1:0]  serve_ticket;
  logic [TW-1:0]  next_ticket;
  logic [1:0]     open_tellers;
  logic [NT-1:0]  teller_busy;

  modport master (
    output arrive_pb, teller_pb, teller_en,
    input  q_count, EF, FF, arrive_rej,
    input  serve_valid, serve_teller,
    input  serve_ticket, next_ticket,
    input  open_tellers, teller_busy
  );

  modport slave (
    input  arrive_pb, teller_pb, teller_en,
    output q_count, EF, FF, arrive_rej,
    output serve_valid, serve_teller,
    output serve_ticket, next_ticket,
    output open_tellers, teller_busy
  );

endinterface

// File: rtl/pb_sync_edge.sv
// Raw push button to one-cycle pulse: 2-FF sync,
// delayed copy, registered rising-edge detect.
module pb_sync_edge (
  input  logic clk,
  input  logic RST,
  input  logic pb_in,
  output logic pulse_out
);

  logic s1, s2, s3;

  // synchronise, then pulse once per rising edge
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      s1        <= pb_in;
      s2        <= s1;
      s3        <= s2;
      pulse_out <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/teller_dispatch.sv
// Bank queue dispatcher: counts arrivals, issues tickets
// and grants the head customer to tellers round-robin.
module teller_dispatch
  import bank_pkg::*;
(
  input logic           clk,
  input logic           RST,
  teller_dispatch_if.slave bus
);

  logic           a_pulse;
  logic [NT-1:0]  t_pulse;
  logic [NT-1:0]  req, gnt, pend_n, pend;
  logic [TIW-1:0] rr_nxt, gidx, srv_t;
  logic           hit, do_gnt, arr_ok;
  int             sidx;
  logic [QW:0]    q_sum;
  logic [QW-1:0]  q_n, q_cnt;
  logic [2:0]     ocnt;
  logic [1:0]     open_n, open_t;
  logic           ef, ff, rej, sv;
  logic [TW-1:0]  nxt_tk, srv_tk;

  pb_sync_edge u_arr (
    .clk       (clk),
    .RST       (RST),
    .pb_in     (bus.arrive_pb),
    .pulse_out (a_pulse)
  );

  for (genvar g = 0; g < NT; g++) begin : g_tsync
    pb_sync_edge u_t (
      .clk       (clk),
      .RST       (RST),
      .pb_in     (bus.teller_pb[g]),
      .pulse_out (t_pulse[g])
    );
  end

  // requests, round-robin pick and next queue count
  always_comb begin
    req  = (pend | t_pulse) & bus.teller_en;
    hit  = 1'b0;
    gidx = '0;
    sidx = 0;
    for (int k = 0; k < NT; k++) begin
      sidx = (int'(rr_nxt) + k) % NT;
      if (!hit && req[sidx]) begin
        hit  = 1'b1;
        gidx = TIW'(sidx);
      end
    end
    do_gnt = hit && (q_cnt != '0);
    gnt    = do_gnt ? (NT'(1) << gidx) : '0;
    pend_n = req & ~gnt;
    arr_ok = a_pulse &&
             ((q_cnt < QW'(QDEPTH)) || do_gnt);
    q_sum  = {1'b0, q_cnt}
           + {{QW{1'b0}}, arr_ok}
           - {{QW{1'b0}}, do_gnt};
    q_n    = (q_sum > (QW+1)'(QDEPTH)) ?
             '0 : q_sum[QW-1:0];
  end

  // open teller count for the ROM address field
  always_comb begin
    ocnt = '0;
    for (int i = 0; i < NT; i++)
      ocnt = ocnt + 3'(bus.teller_en[i]);
    open_n = (ocnt == '0) ? '0 : 2'(ocnt - 3'd1);
  end

  // queue, ticket and grant state
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      q_cnt  <= '0;
      ef     <= 1'b1;
      ff     <= 1'b0;
      pend   <= '0;
      rej    <= 1'b0;
      sv     <= 1'b0;
      nxt_tk <= '0;
      srv_tk <= '0;
      srv_t  <= '0;
      rr_nxt <= '0;
      open_t <= '0;
    end else begin
      q_cnt  <= q_n;
      ef     <= (q_n == '0);
      ff     <= (q_n == QW'(QDEPTH));
      pend   <= pend_n;
      rej    <= a_pulse & ~arr_ok;
      sv     <= do_gnt;
      open_t <= open_n;
      if (arr_ok)
        nxt_tk <= wrap_inc(nxt_tk);
      if (do_gnt) begin
        srv_tk <= wrap_inc(srv_tk);
        srv_t  <= gidx;
        rr_nxt <= (int'(gidx) == NT-1) ?
                  '0 : gidx + 1'b1;
      end
    end
  end

  assign bus.q_count      = q_cnt;
  assign bus.EF           = ef;
  assign bus.FF           = ff;
  assign bus.arrive_rej   = rej;
  assign bus.serve_valid  = sv;
  assign bus.serve_teller = srv_t;
  assign bus.serve_ticket = srv_tk;
  assign bus.next_ticket  = nxt_tk;
  assign bus.open_tellers = open_t;
  assign bus.teller_busy  = pend;

endmodule

// File: tb/tb_teller_dispatch.sv
// Directed bench for teller_dispatch with a serve
// scoreboard and a queue/ticket invariant monitor.
module tb_teller_dispatch;

  logic clk = 1'b0;
  logic RST = 1'b0;

  teller_dispatch_if bus ();

  teller_dispatch dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] t;
    logic [7:0] k;
  } exp_t;

  exp_t sq[$];
  int   rej_exp = 0;
  int   total   = 0;
  int   bad     = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] t,
                      input logic [7:0] k);
    exp_t e;
    e.t = t;
    e.k = k;
    sq.push_back(e);
  endtask

  // serve scoreboard, reject counter, invariant
  always @(negedge clk) begin
    exp_t e;
    int d;
    if (RST === 1'b1) begin
      d = (int'(bus.next_ticket) + 100
          - int'(bus.serve_ticket)) % 100;
      total++;
      if (int'(bus.q_count) != d) begin
        bad++;
        $display("FAIL invariant: got %0d want %0d",
                 bus.q_count, d);
      end
      if (bus.serve_valid) begin
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL serve_unexp: got t%0d k%0d want none",
                   bus.serve_teller, bus.serve_ticket);
        end else begin
          e = sq.pop_front();
          if (bus.serve_teller !== e.t ||
              bus.serve_ticket !== e.k) begin
            bad++;
            $display("FAIL serve: got t%0d k%0d want t%0d k%0d",
                     bus.serve_teller, bus.serve_ticket,
                     e.t, e.k);
          end
        end
      end
      if (bus.arrive_rej) begin
        total++;
        if (rej_exp == 0) begin
          bad++;
          $display("FAIL rej_unexp: got 1 want 0");
        end else begin
          rej_exp--;
        end
      end
    end
  end

  task automatic press(input logic a,
                       input logic [3:0] t);
    @(negedge clk);
    bus.arrive_pb = a;
    bus.teller_pb = t;
    repeat (3) @(negedge clk);
    bus.arrive_pb = 1'b0;
    bus.teller_pb = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_q"},    32'(bus.q_count), 0);
    chk({nm, "_ef"},   32'(bus.EF), 1);
    chk({nm, "_ff"},   32'(bus.FF), 0);
    chk({nm, "_sv"},   32'(bus.serve_valid), 0);
    chk({nm, "_rej"},  32'(bus.arrive_rej), 0);
    chk({nm, "_st"},   32'(bus.serve_teller), 0);
    chk({nm, "_stk"},  32'(bus.serve_ticket), 0);
    chk({nm, "_ntk"},  32'(bus.next_ticket), 0);
    chk({nm, "_open"}, 32'(bus.open_tellers), 0);
    chk({nm, "_busy"}, 32'(bus.teller_busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.arrive_pb = 1'b0;
    bus.teller_pb = '0;
    bus.teller_en = '0;
    RST = 1'b0;
    repeat (2) @(negedge clk);
    RST = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.arrive_pb = 1'b0;
    bus.teller_pb = '0;
    bus.teller_en = '0;
    repeat (2) @(negedge clk);
    chk_reset("por");
    RST = 1'b1;
    repeat (2) @(negedge clk);

    // 1: reset mid-operation
    for (int i = 0; i < 5; i++) press(1'b1, 4'b0);
    chk("t1_q5",   32'(bus.q_count), 5);
    chk("t1_ntk5", 32'(bus.next_ticket), 5);
    bus.teller_en = 4'b0011;
    @(negedge clk);
    bus.teller_pb = 4'b0011;
    @(negedge clk);
    RST = 1'b0;
    #1;
    chk_reset("t1_rst");
    bus.arrive_pb = 1'b1;
    repeat (3) @(negedge clk);
    bus.arrive_pb = 1'b0;
    bus.teller_pb = '0;
    repeat (3) @(negedge clk);
    chk("t1_held_q", 32'(bus.q_count), 0);
    RST = 1'b1;
    repeat (6) @(negedge clk);
    chk("t1_post_q",    32'(bus.q_count), 0);
    chk("t1_post_busy", 32'(bus.teller_busy), 0);
    chk("t1_post_ntk",  32'(bus.next_ticket), 0);

    // 2: fill with no tellers
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) rej_exp++;
      press(1'b1, 4'b0);
      chk("t2_q", 32'(bus.q_count), (i > 7) ? 7 : i);
      chk("t2_ff", 32'(bus.FF), (i >= 7) ? 1 : 0);
    end
    chk("t2_ntk", 32'(bus.next_ticket), 7);
    chk("t2_ef",  32'(bus.EF), 0);

    // 3: round-robin across four tellers
    do_reset();
    bus.teller_en = 4'b1111;
    for (int i = 0; i < 4; i++) press(1'b1, 4'b0);
    chk("t3_q4",   32'(bus.q_count), 4);
    chk("t3_open", 32'(bus.open_tellers), 3);
    for (int i = 0; i < 4; i++)
      push(2'(i), 8'(i + 1));
    press(1'b0, 4'b1111);
    repeat (4) @(negedge clk);
    chk("t3_q0",   32'(bus.q_count), 0);
    chk("t3_ef",   32'(bus.EF), 1);
    chk("t3_stk",  32'(bus.serve_ticket), 4);
    chk("t3_drain", 32'(sq.size()), 0);

    // 4: teller waits on empty queue
    do_reset();
    bus.teller_en = 4'b1111;
    press(1'b0, 4'b0100);
    chk("t4_busy", 32'(bus.teller_busy), 4'b0100);
    push(2'd2, 8'd1);
    press(1'b1, 4'b0);
    chk("t4_q",     32'(bus.q_count), 0);
    chk("t4_busy0", 32'(bus.teller_busy), 0);
    chk("t4_drain", 32'(sq.size()), 0);

    // 5: arrival and grant together at full
    do_reset();
    for (int i = 0; i < 7; i++) press(1'b1, 4'b0);
    chk("t5_ff0", 32'(bus.FF), 1);
    bus.teller_en = 4'b0001;
    push(2'd0, 8'd1);
    press(1'b1, 4'b0001);
    chk("t5_q",   32'(bus.q_count), 7);
    chk("t5_ff",  32'(bus.FF), 1);
    chk("t5_ntk", 32'(bus.next_ticket), 8);
    chk("t5_stk", 32'(bus.serve_ticket), 1);

    // 6: ticket wrap and teller disable
    do_reset();
    bus.teller_en = 4'b0001;
    for (int k = 1; k <= 99; k++) begin
      push(2'd0, 8'(k));
      press(1'b1, 4'b0001);
    end
    chk("t6_ntk99", 32'(bus.next_ticket), 99);
    chk("t6_stk99", 32'(bus.serve_ticket), 99);
    bus.teller_en = 4'b0010;
    press(1'b0, 4'b0010);
    chk("t6_busy1", 32'(bus.teller_busy), 4'b0010);
    bus.teller_en = 4'b0000;
    repeat (2) @(negedge clk);
    chk("t6_busy_clr", 32'(bus.teller_busy), 0);
    bus.teller_en = 4'b0011;
    repeat (2) @(negedge clk);
    chk("t6_open", 32'(bus.open_tellers), 1);
    press(1'b1, 4'b0);
    chk("t6_ntk_wrap", 32'(bus.next_ticket), 0);
    chk("t6_q1",       32'(bus.q_count), 1);
    push(2'd0, 8'd0);
    press(1'b0, 4'b0001);
    repeat (2) @(negedge clk);
    chk("t6_stk_wrap", 32'(bus.serve_ticket), 0);
    chk("t6_q0",       32'(bus.q_count), 0);

    chk("end_sq",  32'(sq.size()), 0);
    chk("end_rej", 32'(rej_exp), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
